// File: rtl/sram_rw_ctrl.sv
// ---------------------------------------------------------------------------
// sram_rw_ctrl
//
// Access controller for a single-port SRAM macro (default 8192 x 64). It
// arbitrates independent read and write request streams onto the macro's one
// RW port, captures read data the cycle after issue and returns it in request
// order through a small response FIFO with valid/ready backpressure. This
// block owns every macro control signal.
//
// Ports
//   clock          rising-edge clock, shared with the macro
//   reset_n        asynchronous active-low reset
//   rd_req_valid   read request valid
//   rd_req_ready   read request accepted this cycle (with valid)
//   rd_req_addr    read address
//   wr_req_valid   write request valid
//   wr_req_ready   write request accepted this cycle (with valid)
//   wr_req_addr    write address
//   wr_req_data    write data
//   rd_resp_valid  head of response FIFO valid
//   rd_resp_ready  consumer takes the head
//   rd_resp_data   read data, in request order
//   sram_en        macro RW0_en
//   sram_wmode     macro RW0_wmode (1 = write)
//   sram_addr      macro RW0_addr
//   sram_wdata     macro RW0_wdata
//   sram_rdata     macro RW0_rdata
//   busy           read in flight or response FIFO non-empty
//
// Configuration
//   SRAM_CTRL_WPRIO_EN  when defined, writes win every contested cycle
//                       (fixed priority). Default: round-robin arbitration.
// ---------------------------------------------------------------------------
module sram_rw_ctrl #(
  parameter int ADDR_W     = 13,
  parameter int DATA_W     = 64,
  parameter int RESP_DEPTH = 3
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_req_addr,
  input  logic              wr_req_valid,
  output logic              wr_req_ready,
  input  logic [ADDR_W-1:0] wr_req_addr,
  input  logic [DATA_W-1:0] wr_req_data,
  output logic              rd_resp_valid,
  input  logic              rd_resp_ready,
  output logic [DATA_W-1:0] rd_resp_data,
  output logic              sram_en,
  output logic              sram_wmode,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic              busy
);

  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam int CNT_W = $clog2(RESP_DEPTH + 1);

  localparam logic GRANT_RD = 1'b0;
  localparam logic GRANT_WR = 1'b1;

  logic              inflight_q, inflight_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic              last_grant_q, last_grant_d;
  logic [DATA_W-1:0] fifo_mem [RESP_DEPTH];

  logic              rd_elig;
  logic              rd_fire;
  logic              wr_fire;
  logic              push;
  logic              pop;
  logic [CNT_W:0]    credits_used;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RESP_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // A read reserves a FIFO slot from issue until its response is popped. A
  // pop in the current cycle is deliberately not credited so that the
  // request-side ready never depends combinationally on rd_resp_ready.
  assign credits_used = {1'b0, count_q} + (CNT_W + 1)'(inflight_q);
  assign rd_elig      = credits_used < (CNT_W + 1)'(RESP_DEPTH);

  always_comb begin
    rd_req_ready = 1'b0;
    wr_req_ready = 1'b0;
    if (reset_n) begin
`ifdef SRAM_CTRL_WPRIO_EN
      wr_req_ready = 1'b1;
      rd_req_ready = rd_elig & ~wr_req_valid;
`else
      // The two readies are mutually exclusive whenever both sides compete,
      // so at most one request fires per cycle.
      rd_req_ready = rd_elig & (~wr_req_valid | (last_grant_q == GRANT_WR));
      wr_req_ready = ~(rd_req_valid & rd_elig) | (last_grant_q == GRANT_RD);
`endif
    end
  end

  assign rd_fire = rd_req_valid & rd_req_ready;
  assign wr_fire = wr_req_valid & wr_req_ready;

  // Macro port is driven straight from the winning request; idle drives 0.
  always_comb begin
    sram_en    = rd_fire | wr_fire;
    sram_wmode = wr_fire;
    sram_addr  = '0;
    sram_wdata = '0;
    if (wr_fire) begin
      sram_addr = wr_req_addr;
    end else if (rd_fire) begin
      sram_addr = rd_req_addr;
    end
    if (rd_fire | wr_fire) begin
      sram_wdata = wr_req_data;
    end
  end

  // The macro presents read data the cycle after issue; that is the only
  // cycle in which sram_rdata is sampled.
  assign push          = inflight_q;
  assign rd_resp_valid = (count_q != '0);
  assign pop           = rd_resp_valid & rd_resp_ready;
  assign rd_resp_data  = fifo_mem[rd_ptr_q];
  assign busy          = inflight_q | rd_resp_valid;

  always_comb begin
    inflight_d   = rd_fire;
    last_grant_d = last_grant_q;
    if (wr_fire) begin
      last_grant_d = GRANT_WR;
    end else if (rd_fire) begin
      last_grant_d = GRANT_RD;
    end
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      inflight_q   <= 1'b0;
      count_q      <= '0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      last_grant_q <= GRANT_WR;
    end else begin
      inflight_q   <= inflight_d;
      count_q      <= count_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Response storage carries data only; occupancy is tracked by count_q.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_mem[wr_ptr_q] <= sram_rdata;
    end
  end

  // Read credits make a push into a full FIFO (without a pop) impossible.
  a_no_overflow: assert property (@(posedge clock) disable iff (!reset_n)
    !(push && !pop && (count_q == CNT_W'(RESP_DEPTH))));

endmodule

// File: tb/tb_sram_rw_ctrl.sv
module tb_sram_rw_ctrl;

  localparam int ADDR_W = 13;
  localparam int DATA_W = 64;
  localparam int DEPTH  = 3;

  localparam logic [1:0] G_NONE = 2'd0;
  localparam logic [1:0] G_RD   = 2'd1;
  localparam logic [1:0] G_WR   = 2'd2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              rd_req_valid = 1'b0;
  logic              rd_req_ready;
  logic [ADDR_W-1:0] rd_req_addr = '0;
  logic              wr_req_valid = 1'b0;
  logic              wr_req_ready;
  logic [ADDR_W-1:0] wr_req_addr = '0;
  logic [DATA_W-1:0] wr_req_data = '0;
  logic              rd_resp_valid;
  logic              rd_resp_ready = 1'b0;
  logic [DATA_W-1:0] rd_resp_data;
  logic              sram_en;
  logic              sram_wmode;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic              busy;

  always #5 clock = ~clock;

  sram_rw_ctrl #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .RESP_DEPTH (DEPTH)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .rd_req_valid  (rd_req_valid),
    .rd_req_ready  (rd_req_ready),
    .rd_req_addr   (rd_req_addr),
    .wr_req_valid  (wr_req_valid),
    .wr_req_ready  (wr_req_ready),
    .wr_req_addr   (wr_req_addr),
    .wr_req_data   (wr_req_data),
    .rd_resp_valid (rd_resp_valid),
    .rd_resp_ready (rd_resp_ready),
    .rd_resp_data  (rd_resp_data),
    .sram_en       (sram_en),
    .sram_wmode    (sram_wmode),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_rdata    (sram_rdata),
    .busy          (busy)
  );

  // Preload contents shared by the macro model and the reference memory.
  function automatic logic [63:0] init_val(input int a);
    if (a == 16) return 64'hDEADBEEF_00000001;
    return {32'hC0DE0000 | 32'(a), ~32'(a)};
  endfunction

  // Behavioural macro: synchronous read returning pre-write contents.
  logic [63:0] sram_mem [8192];
  always @(posedge clock) begin
    if (sram_en) begin
      if (sram_wmode) sram_mem[sram_addr] <= sram_wdata;
      else            sram_rdata <= sram_mem[sram_addr];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: a read's data is fixed at acceptance (memory contents
  // at that moment); it becomes visible two cycles later and stays at the
  // head of an in-order queue until consumed.
  logic [63:0] ref_mem [8192];
  logic [63:0] ref_q [$];
  logic        m_inflight = 1'b0;
  logic [63:0] m_data = '0;
  logic        m_last_wr = 1'b1;

  function automatic logic [1:0] model_grant();
    logic elig;
    if (!reset_n) return G_NONE;
    elig = (int'(m_inflight) + ref_q.size()) < DEPTH;
`ifdef SRAM_CTRL_WPRIO_EN
    if (wr_req_valid) return G_WR;
    if (rd_req_valid && elig) return G_RD;
    return G_NONE;
`else
    if (rd_req_valid && elig && wr_req_valid) return m_last_wr ? G_RD : G_WR;
    if (rd_req_valid && elig) return G_RD;
    if (wr_req_valid) return G_WR;
    return G_NONE;
`endif
  endfunction

  always @(posedge clock or negedge reset_n) begin : model
    logic [1:0] g;
    if (!reset_n) begin
      ref_q.delete();
      m_inflight = 1'b0;
      m_last_wr  = 1'b1;
    end else begin
      g = model_grant();
      if (ref_q.size() != 0 && rd_resp_ready) void'(ref_q.pop_front());
      if (m_inflight) ref_q.push_back(m_data);
      m_inflight = (g == G_RD);
      if (g == G_RD) m_data = ref_mem[rd_req_addr];
      if (g == G_WR) ref_mem[wr_req_addr] = wr_req_data;
      if (g != G_NONE) m_last_wr = (g == G_WR);
    end
  end

  always @(negedge clock) begin : cmp
    logic [1:0] g;
    g = model_grant();
    chk("busy", 64'(busy), 64'(m_inflight || ref_q.size() != 0));
    chk("rd_resp_valid", 64'(rd_resp_valid), 64'(ref_q.size() != 0));
    if (ref_q.size() != 0) chk("rd_resp_data", rd_resp_data, ref_q[0]);
    if (rd_req_valid || !reset_n) chk("rd_req_ready", 64'(rd_req_ready), 64'(g == G_RD));
    if (wr_req_valid || !reset_n) chk("wr_req_ready", 64'(wr_req_ready), 64'(g == G_WR));
    chk("sram_en", 64'(sram_en), 64'(g != G_NONE));
    chk("sram_wmode", 64'(sram_wmode), 64'(g == G_WR));
    chk("sram_addr", 64'(sram_addr),
        (g == G_RD) ? 64'(rd_req_addr) : (g == G_WR) ? 64'(wr_req_addr) : 64'd0);
    chk("sram_wdata", sram_wdata, (g != G_NONE) ? wr_req_data : 64'd0);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int acc;
    int ri;
    int wi;
    logic [15:0] pat;
    for (int a = 0; a < 8192; a++) begin
      sram_mem[a] <= init_val(a);
      ref_mem[a]  = init_val(a);
    end

    // Reset: readies held low even with requests pending.
    rd_req_valid = 1'b1;
    wr_req_valid = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_rd_ready", 64'(rd_req_ready), 64'd0);
    chk("rst_wr_ready", 64'(wr_req_ready), 64'd0);
    chk("rst_sram_en", 64'(sram_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    tick();
    reset_n = 1'b1;

    // Single read of 0x0010, two-cycle latency.
    repeat (4) tick();
    rd_resp_ready = 1'b1;
    rd_req_valid  = 1'b1;
    rd_req_addr   = 13'h0010;
    @(negedge clock);
    chk("single_issue_en", 64'(sram_en), 64'd1);
    chk("single_busy_t", 64'(busy), 64'd0);
    tick();
    rd_req_valid = 1'b0;
    @(negedge clock);
    chk("single_busy_t1", 64'(busy), 64'd1);
    chk("single_nvalid_t1", 64'(rd_resp_valid), 64'd0);
    tick();
    @(negedge clock);
    chk("single_valid_t2", 64'(rd_resp_valid), 64'd1);
    chk("single_data_t2", rd_resp_data, 64'hDEADBEEF_00000001);
    chk("single_busy_t2", 64'(busy), 64'd1);
    tick();
    @(negedge clock);
    chk("single_idle_t3", 64'(busy), 64'd0);

    // 16 back-to-back reads, responses on consecutive cycles.
    for (int i = 0; i < 18; i++) begin
      tick();
      rd_req_valid = (i < 16);
      rd_req_addr  = 13'(i);
      @(negedge clock);
      if (i < 16) chk("b2b_ready", 64'(rd_req_ready), 64'd1);
      if (i >= 2) begin
        chk("b2b_valid", 64'(rd_resp_valid), 64'd1);
        chk("b2b_data", rd_resp_data, init_val(i - 2));
      end
    end

    // Backpressure: exactly DEPTH reads accepted with the consumer stalled.
    tick();
    rd_resp_ready = 1'b0;
    rd_req_valid  = 1'b1;
    rd_req_addr   = 13'h020;
    acc = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      if (rd_req_ready) acc++;
      tick();
      rd_req_addr = 13'(32 + acc);
    end
    chk("bp_accepted", 64'(acc), 64'd3);
    tick();
    rd_resp_ready = 1'b1;
    @(negedge clock);
    chk("bp_ready_full", 64'(rd_req_ready), 64'd0);
    chk("bp_data0", rd_resp_data, init_val(32));
    tick();
    @(negedge clock);
    chk("bp_resume", 64'(rd_req_ready), 64'd1);
    chk("bp_data1", rd_resp_data, init_val(33));
    tick();
    rd_req_valid = 1'b0;
    @(negedge clock);
    chk("bp_data2", rd_resp_data, init_val(34));
    repeat (4) tick();

    // Irregular consumer: simultaneous push/pop at various occupancies.
    pat = 16'b1011_0010_1101_0110;
    for (int j = 0; j < 16; j++) begin
      tick();
      rd_req_valid  = 1'b1;
      rd_req_addr   = 13'(64 + j);
      rd_resp_ready = pat[j];
    end
    tick();
    rd_req_valid  = 1'b0;
    rd_resp_ready = 1'b1;
    repeat (6) tick();

    // Reset mid-flight with two responses buffered and one in flight.
    rd_resp_ready = 1'b0;
    rd_req_valid  = 1'b1;
    rd_req_addr   = 13'h030;
    tick();
    rd_req_addr = 13'h031;
    tick();
    rd_req_addr = 13'h032;
    tick();
    rd_req_valid = 1'b0;
    @(negedge clock);
    chk("mid_busy", 64'(busy), 64'd1);
    chk("mid_valid", 64'(rd_resp_valid), 64'd1);
    #2;
    reset_n      = 1'b0;
    rd_req_valid = 1'b1;
    wr_req_valid = 1'b1;
    #1;
    chk("arst_valid", 64'(rd_resp_valid), 64'd0);
    chk("arst_busy", 64'(busy), 64'd0);
    chk("arst_en", 64'(sram_en), 64'd0);
    chk("arst_rd_ready", 64'(rd_req_ready), 64'd0);
    chk("arst_wr_ready", 64'(wr_req_ready), 64'd0);
    tick();
    rd_req_valid  = 1'b0;
    wr_req_valid  = 1'b0;
    rd_resp_ready = 1'b1;
    tick();
    reset_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("post_rst_valid", 64'(rd_resp_valid), 64'd0);
      chk("post_rst_busy", 64'(busy), 64'd0);
      tick();
    end

    // Contention: both streams valid every cycle.
    ri = 0;
    wi = 0;
    for (int k = 0; k < 8; k++) begin
      rd_req_valid = 1'b1;
      wr_req_valid = 1'b1;
      rd_req_addr  = 13'(32'h200 + ri);
      wr_req_addr  = 13'(32'h100 + wi);
      wr_req_data  = 64'hBEEF_0000 + 64'(wi);
      @(negedge clock);
`ifdef SRAM_CTRL_WPRIO_EN
      chk("arb_wprio_wr", 64'(sram_wmode), 64'd1);
      chk("arb_wprio_rd_ready", 64'(rd_req_ready), 64'd0);
`else
      chk("arb_rr_grant", 64'(sram_wmode), 64'(k % 2));
`endif
      if (rd_req_ready) ri++;
      if (wr_req_ready) wi++;
      tick();
    end
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b0;
    repeat (4) tick();

    // Write then read of 0x1FFF; a later write must not disturb the response.
    wr_req_valid = 1'b1;
    wr_req_addr  = 13'h1FFF;
    wr_req_data  = 64'hA5A5;
    tick();
    wr_req_valid = 1'b0;
    rd_req_valid = 1'b1;
    rd_req_addr  = 13'h1FFF;
    tick();
    rd_req_valid = 1'b0;
    wr_req_valid = 1'b1;
    wr_req_data  = 64'h5A5A;
    @(negedge clock);
    chk("raw_nvalid_t2", 64'(rd_resp_valid), 64'd0);
    tick();
    wr_req_valid = 1'b0;
    @(negedge clock);
    chk("raw_valid_t3", 64'(rd_resp_valid), 64'd1);
    chk("raw_data_t3", rd_resp_data, 64'hA5A5);
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sram_rw_ctrl.md
# sram_rw_ctrl

Single-port SRAM access controller that sits directly upstream of the 8192x64 single-port array macro. It accepts independent read and write request streams (valid/ready) and arbitrates them onto the macro's one RW port. It captures read data in the cycle after issue and returns it through a small response FIFO with valid/ready backpressure. It owns all macro control signals; nothing else drives the array.

## Interface
Parameters:
- ADDR_W, 13, SRAM address width
- DATA_W, 64, SRAM data width
- RESP_DEPTH, 3, response FIFO entries (legal range 2..8)

Ports:
- clock  in  1  rising-edge clock, shared with the SRAM macro
- reset_n  in  1  asynchronous, active-low reset
- rd_req_valid  in  1  read request valid
- rd_req_ready  out  1  read request accepted this cycle when high with valid
- rd_req_addr  in  ADDR_W  read address
- wr_req_valid  in  1  write request valid
- wr_req_ready  out  1  write request accepted this cycle when high with valid
- wr_req_addr  in  ADDR_W  write address
- wr_req_data  in  DATA_W  write data
- rd_resp_valid  out  1  head of response FIFO valid
- rd_resp_ready  in  1  consumer takes the head
- rd_resp_data  out  DATA_W  read data, in request order
- sram_en  out  1  to macro RW0_en
- sram_wmode  out  1  to macro RW0_wmode
- sram_addr  out  ADDR_W  to macro RW0_addr
- sram_wdata  out  DATA_W  to macro RW0_wdata
- sram_rdata  in  DATA_W  from macro RW0_rdata
- busy  out  1  read in flight or response FIFO non-empty

## Operation
- Read fire = rd_req_valid & rd_req_ready. Write fire = wr_req_valid & wr_req_ready. At most one fires per cycle.
- Read eligibility: (inflight + count) < RESP_DEPTH.
  - inflight = 1-bit register, set for the cycle after a read fire.
  - count = FIFO occupancy.
  - A pop in the same cycle is not credited, so ready never depends combinationally on rd_resp_ready.
- Writes are always eligible; they have no response.
- Arbitration (default): round-robin on a 1-bit last_grant register. When both sides are valid and eligible, grant the side opposite last_grant. When only one side is valid/eligible, grant it. last_grant updates on every fire. Reset value of last_grant = write, so the first contested cycle grants the read.
- Fire drives macro combinationally in the same cycle: sram_en=1, sram_wmode=1 for write / 0 for read, sram_addr=request addr, sram_wdata=wr_req_data. With no fire: sram_en=0, wmode=0, addr/wdata=0.
- While inflight=1, sram_rdata is pushed into the FIFO at the end of that cycle. sram_rdata is ignored in every other cycle.
- FIFO: circular buffer with wrapping rd/wr pointers. Simultaneous push and pop are legal in any state, including full-minus-one and empty-with-push. Count stays consistent in all cases. Credits guarantee a push never hits full; an overflow is a design error, flagged by assertion.
- busy = inflight | (count != 0).

## Timing
- Read accepted in cycle t → macro read at t → sram_rdata valid in t+1 → FIFO push at end of t+1 → rd_resp_valid high in t+2. Fixed latency of 2 when the FIFO is empty.
- Sustained read throughput is 1 per cycle when rd_resp_ready=1 and RESP_DEPTH≥3. RESP_DEPTH=2 limits it to 2 per 3 cycles.
- A write in t+1 after a read in t does not alter the read data, because the macro returns pre-write contents.
- Write then read of the same address in consecutive cycles returns the new data.
- Reset (async, reset_n low):
  - inflight=0, count=0, pointers=0, last_grant=write.
  - rd_resp_valid=0, rd_req_ready=0, wr_req_ready=0, sram_en=0, busy=0.
  - Reset mid-flight discards in-flight and buffered responses; no response is produced for them after release.
- First acceptance is possible in the first clock cycle with reset_n high.

## Configuration
- SRAM_CTRL_WPRIO_EN defined: fixed priority. A write wins every contested cycle. last_grant is still maintained, but arbitration ignores it. Reads can starve under continuous writes.
- Undefined: round-robin as described above.

## Test plan
- Single read of address 0x0010 preloaded with 0xDEADBEEF_00000001, issued in cycle 5 → rd_resp_valid in cycle 7 with that data; busy high for cycles 6–7.
- 16 back-to-back reads of addresses 0..15 with rd_resp_ready=1 → rd_req_ready never drops; 16 responses in order on consecutive cycles.
- rd_resp_ready=0 with continuous read requests → exactly 3 reads accepted; rd_req_ready=0 after that. Releasing ready yields 3 in-order responses, then acceptance resumes.
- Both streams valid continuously (writes to 0x100+i, reads to 0x200+i) → grants alternate R,W,R,W starting with R. With SRAM_CTRL_WPRIO_EN → all writes are granted, rd_req_ready=0.
- Write 0xA5A5 to 0x1FFF in cycle t, read 0x1FFF in cycle t+1 → response 0xA5A5 in cycle t+3.
- Assert reset_n low in the cycle after a read is accepted, with 2 responses buffered → all outputs return to their reset values immediately; no rd_resp_valid after release until a new read is accepted.
